// File: rtl/ucsbece154a_dmem_ctrl_if.sv
// Load/store request/response bundle between the datapath and the data-memory controller.
// Latency: none, wires only.
// Backpressure: requester holds req_i until the one-cycle ready_o response pulse.
interface ucsbece154a_dmem_ctrl_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic        ready_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        busy_o;

    // Datapath side: issues requests, consumes responses.
    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i,
        input  ready_o, rdata_o, err_o, busy_o
    );

    // Controller side.
    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i,
        output ready_o, rdata_o, err_o, busy_o
    );
endinterface

// File: rtl/ucsbece154a_dmem_ctrl.sv
// Data-memory controller: one request at a time, byte-lane stores, registered full-word loads.
// Latency: ready_o on the (WAIT_CYCLES+1)th posedge counting the accepting edge as the first.
// Backpressure: req_i ignored while in WAIT; a request held through RESP is accepted with no bubble.
// Optional DMEM_ERR_EN: range/alignment checking with err_o; otherwise the index wraps and err_o is 0.
module ucsbece154a_dmem_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          DEPTH       = 64,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    ucsbece154a_dmem_ctrl_if.slave   bus
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;

    // Request captured on the accepting edge; inputs are ignored afterwards.
    logic        q_we;
    logic [31:0] q_addr;
    logic [31:0] q_wdata;
    logic [3:0]  q_be;

    // The request being committed on this edge (the edge that enters RESP).
    logic             c_vld;
    logic             c_we;
    logic [31:0]      c_addr;
    logic [31:0]      c_wdata;
    logic [3:0]       c_be;
    logic [31:0]      c_off;
    logic [IDX_W-1:0] c_idx;
    logic             c_err;
    logic             unused_off_bits;

    logic             accept;
    logic             err_q;
    logic [31:0]      rdata_q;

    logic [31:0] mem [DEPTH];

    assign accept = bus.req_i && ((state == S_IDLE) || (state == S_RESP));

    // State and wait counter; reset abandons any request in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: IDLE/RESP accept, WAIT counts down to zero then responds.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE, S_RESP: begin
                if (bus.req_i) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt = S_RESP;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Capture the request fields on the accepting edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_we    <= 1'b0;
            q_addr  <= 32'd0;
            q_wdata <= 32'd0;
            q_be    <= 4'd0;
        end else if (accept) begin
            q_we    <= bus.we_i;
            q_addr  <= bus.addr_i;
            q_wdata <= bus.wdata_i;
            q_be    <= bus.be_i;
        end
    end

    // Select the committing request: latched fields after WAIT, live inputs when there are no wait states.
    always_comb begin
        c_vld   = 1'b0;
        c_we    = q_we;
        c_addr  = q_addr;
        c_wdata = q_wdata;
        c_be    = q_be;
        if (state == S_WAIT) begin
            c_vld = reset_n && (cnt == 4'd0);
        end else if (WAIT_CYCLES == 0) begin
            c_vld   = reset_n && accept;
            c_we    = bus.we_i;
            c_addr  = bus.addr_i;
            c_wdata = bus.wdata_i;
            c_be    = bus.be_i;
        end
    end

    assign c_off = c_addr - BASE_ADDR;
    assign c_idx = c_off[IDX_W+1:2];
    assign unused_off_bits = ^{c_off[31:IDX_W+2], c_off[1:0]};

    // Access checking: out-of-window offset, or misaligned load / misaligned store with any lane enabled.
    always_comb begin
        c_err = 1'b0;
`ifdef DMEM_ERR_EN
        c_err = (c_off >= 32'(4 * DEPTH)) ||
                ((c_addr[1:0] != 2'b00) && (!c_we || (c_be != 4'b0000)));
`endif
    end

    // Byte-lane store into the word array on the edge entering RESP; errored stores are dropped.
    always_ff @(posedge clk) begin
        if (c_vld && c_we && !c_err) begin
            for (int k = 0; k < 4; k++) begin
                if (c_be[k]) begin
                    mem[c_idx][8*k +: 8] <= c_wdata[8*k +: 8];
                end
            end
        end
    end

    // Response registers: load data (zero on error) and the error flag, held until the next response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (c_vld) begin
            err_q <= c_err;
            if (c_err) begin
                rdata_q <= 32'd0;
            end else if (!c_we) begin
                rdata_q <= mem[c_idx];
            end
        end
    end

    assign bus.ready_o = (state == S_RESP);
    assign bus.err_o   = (state == S_RESP) && err_q;
    assign bus.rdata_o = rdata_q;
    assign bus.busy_o  = (state != S_IDLE);

endmodule
